// File: rtl/csi_rx_lane_deskew_pkg.sv
// Shared types and default configuration for the CSI-2 receive lane deskewer.
package csi_rx_lane_deskew_pkg;

  localparam int unsigned CSI_NUM_LANE = 2;
  localparam int unsigned CSI_MAX_SKEW = 3;
  localparam int unsigned CSI_TAP_W    = $clog2(CSI_MAX_SKEW + 1);

  typedef logic [7:0]           lane_data_t;
  typedef logic                 lane_vld_t;
  typedef logic [CSI_TAP_W-1:0] lane_tap_t;

  // Deskew FSM encoding
  typedef logic [0:0] deskew_state_t;
  localparam deskew_state_t DSK_SEARCH = 1'b0;
  localparam deskew_state_t DSK_LOCKED = 1'b1;

endpackage

// File: rtl/csi_rx_lane_dly.sv
// Single-lane byte+valid delay line of MAX_SKEW+1 stages with a tap-select mux.
module csi_rx_lane_dly
  import csi_rx_lane_deskew_pkg::*;
#(
  parameter int unsigned  MAX_SKEW = CSI_MAX_SKEW,
  localparam int unsigned TAP_W    = $clog2(MAX_SKEW + 1)
) (
  input  logic             byte_clock,
  input  logic             reset,
  input  logic             enable,
  input  lane_data_t       byte_in,
  input  lane_vld_t        valid_in,
  input  logic [TAP_W-1:0] tap,
  output logic [MAX_SKEW:0] stage_vld,
  output lane_data_t       byte_c,
  output lane_vld_t        valid_c
);

  logic [MAX_SKEW:0][7:0] stage_byte;

  // Shift register: stage 0 captures the input, stage k+1 takes stage k
  always_ff @(posedge byte_clock) begin
    if (reset) begin
      stage_byte <= '0;
      stage_vld  <= '0;
    end else if (enable) begin
      stage_byte <= {stage_byte[MAX_SKEW-1:0], byte_in};
      stage_vld  <= {stage_vld[MAX_SKEW-1:0], valid_in};
    end
  end

  // Tap-select mux; out-of-range taps yield an idle byte
  always_comb begin
    byte_c  = '0;
    valid_c = 1'b0;
    for (int k = 0; k <= MAX_SKEW; k++) begin
      if (tap == TAP_W'(k)) begin
        byte_c  = stage_byte[k];
        valid_c = stage_vld[k];
      end
    end
  end

endmodule

// File: rtl/csi_rx_lane_deskew.sv
// Multi-lane word deskewer between the byte aligners and the CSI packet handler.
// Per-lane delay taps are locked on the sync word and held until packet_done.
// Optional error counter enabled by defining CSI_DESKEW_ERRCNT_EN.
module csi_rx_lane_deskew
  import csi_rx_lane_deskew_pkg::*;
#(
  parameter int unsigned  NUM_LANE = CSI_NUM_LANE,
  parameter int unsigned  MAX_SKEW = CSI_MAX_SKEW,
  localparam int unsigned TAP_W    = $clog2(MAX_SKEW + 1)
) (
  input  logic                      byte_clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      packet_done,
  input  logic                      wait_for_sync,
  input  logic [NUM_LANE*8-1:0]     word_in,
  input  logic [NUM_LANE-1:0]       valid_in,
  output logic [NUM_LANE*8-1:0]     word_out,
  output logic                      valid_out,
  output logic                      packet_done_out,
  output logic [NUM_LANE*TAP_W-1:0] taps_out,
  output logic                      skew_err,
  output logic                      drop_err,
  output logic [15:0]               err_count
);

  deskew_state_t state, state_nxt;

  logic [NUM_LANE-1:0][TAP_W-1:0] taps;
  logic [NUM_LANE-1:0][TAP_W-1:0] calc_taps;
  logic [NUM_LANE-1:0][TAP_W-1:0] sel_taps;
  logic [NUM_LANE-1:0][MAX_SKEW:0] stage_vld;
  logic [NUM_LANE-1:0][7:0]       sel_byte;
  logic [NUM_LANE-1:0]            sel_vld;

  logic run;
  logic all_s0;
  logic any_full;
  logic lock_c;
  logic ovf_c;
  logic ovf_q;
  logic skew_set_c;
  logic drop_c;

  // While searching, the mux follows the live tap estimate so the sync word
  // lines up on the lock edge; once locked it uses the held taps.
  assign sel_taps = (state == DSK_LOCKED) ? taps : calc_taps;

  for (genvar g = 0; g < NUM_LANE; g++) begin : g_lane
    csi_rx_lane_dly #(
      .MAX_SKEW (MAX_SKEW)
    ) u_dly (
      .byte_clock (byte_clock),
      .reset      (reset),
      .enable     (enable),
      .byte_in    (word_in[8*g +: 8]),
      .valid_in   (valid_in[g]),
      .tap        (sel_taps[g]),
      .stage_vld  (stage_vld[g]),
      .byte_c     (sel_byte[g]),
      .valid_c    (sel_vld[g])
    );
  end

  // Tap estimate: unbroken valid run from stage 0 upward, minus one
  always_comb begin
    calc_taps = '0;
    run       = 1'b0;
    for (int i = 0; i < NUM_LANE; i++) begin
      run = stage_vld[i][0];
      for (int k = 1; k <= MAX_SKEW; k++) begin
        run = run & stage_vld[i][k];
        if (run) calc_taps[i] = TAP_W'(k);
      end
    end
  end

  // Lane summary flags for lock, overflow and dropout detection
  always_comb begin
    all_s0   = 1'b1;
    any_full = 1'b0;
    for (int i = 0; i < NUM_LANE; i++) begin
      all_s0   = all_s0 & stage_vld[i][0];
      any_full = any_full | (&stage_vld[i]);
    end
  end

  assign lock_c     = (state == DSK_SEARCH) && wait_for_sync && all_s0;
  assign ovf_c      = (state == DSK_SEARCH) && any_full && !all_s0;
  assign skew_set_c = ovf_c && !ovf_q;
  assign drop_c     = (state == DSK_LOCKED) && !packet_done &&
                      (|sel_vld) && !(&sel_vld);

  // State register
  always_ff @(posedge byte_clock) begin
    if (reset) begin
      state <= DSK_SEARCH;
    end else if (enable) begin
      state <= state_nxt;
    end
  end

  // Next-state logic; packet_done wins over dropout
  always_comb begin
    state_nxt = state;
    case (state)
      DSK_SEARCH: if (lock_c) state_nxt = DSK_LOCKED;
      DSK_LOCKED: if (packet_done || drop_c) state_nxt = DSK_SEARCH;
      default:    state_nxt = DSK_SEARCH;
    endcase
  end

  // Tap hold, output register and error pulses
  always_ff @(posedge byte_clock) begin
    if (reset) begin
      taps      <= '0;
      word_out  <= '0;
      valid_out <= 1'b0;
      skew_err  <= 1'b0;
      drop_err  <= 1'b0;
      ovf_q     <= 1'b0;
    end else if (enable) begin
      if (lock_c) taps <= calc_taps;
      word_out  <= sel_byte;
      valid_out <= (state == DSK_LOCKED);
      skew_err  <= skew_set_c;
      drop_err  <= drop_c;
      ovf_q     <= ovf_c;
    end
  end

  assign taps_out        = taps;
  assign packet_done_out = packet_done | skew_err | drop_err;

`ifdef CSI_DESKEW_ERRCNT_EN
  logic [15:0] err_cnt_q;

  // Saturating error counter; simultaneous errors count once
  always_ff @(posedge byte_clock) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else if (enable && (skew_set_c || drop_c) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_csi_rx_lane_deskew.sv
// Directed bench for csi_rx_lane_deskew (2-lane and 4-lane instances).
module tb_csi_rx_lane_deskew;

  logic        byte_clock = 1'b0;
  logic        reset, enable, packet_done, wait_for_sync;
  logic [15:0] word_in, word_out;
  logic [1:0]  valid_in;
  logic        valid_out, packet_done_out, skew_err, drop_err;
  logic [3:0]  taps_out;
  logic [15:0] err_count;

  logic        ws4;
  logic [31:0] word4_in, word4_out;
  logic [3:0]  valid4_in;
  logic        valid4_out, pdo4, skew4, drop4;
  logic [7:0]  taps4;
  logic [15:0] errc4;

  int errors = 0;
  int checks = 0;
  int off4 [4] = '{0, 3, 1, 2};

  always #5 byte_clock = ~byte_clock;

  csi_rx_lane_deskew u_dut (
    .byte_clock      (byte_clock),
    .reset           (reset),
    .enable          (enable),
    .packet_done     (packet_done),
    .wait_for_sync   (wait_for_sync),
    .word_in         (word_in),
    .valid_in        (valid_in),
    .word_out        (word_out),
    .valid_out       (valid_out),
    .packet_done_out (packet_done_out),
    .taps_out        (taps_out),
    .skew_err        (skew_err),
    .drop_err        (drop_err),
    .err_count       (err_count)
  );

  csi_rx_lane_deskew #(.NUM_LANE(4), .MAX_SKEW(3)) u_dut4 (
    .byte_clock      (byte_clock),
    .reset           (reset),
    .enable          (enable),
    .packet_done     (1'b0),
    .wait_for_sync   (ws4),
    .word_in         (word4_in),
    .valid_in        (valid4_in),
    .word_out        (word4_out),
    .valid_out       (valid4_out),
    .packet_done_out (pdo4),
    .taps_out        (taps4),
    .skew_err        (skew4),
    .drop_err        (drop4),
    .err_count       (errc4)
  );

  typedef struct {
    logic [15:0] w;
    logic [1:0]  v;
    logic        ws;
    logic        cw;
    logic [15:0] ew;
    logic        evo;
    logic        epdo;
    logic [3:0]  et;
    logic        edrop;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge byte_clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; packet_done = 1'b0; wait_for_sync = 1'b0;
    word_in = '0; valid_in = '0;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] item(input int n);
    return {8'(128 + n), 8'(n)};
  endfunction

  initial begin
    int n_acc;
    int nskew;

    // w, v, ws, cw, ew, evo, epdo, et, edrop
    tbl[0]  = '{16'h0000, 2'b00, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{16'h00B8, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[2]  = '{16'h0010, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[3]  = '{16'hB811, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h0, 1'b0};
    tbl[4]  = '{16'h2012, 2'b11, 1'b1, 1'b1, 16'hB8B8, 1'b0, 1'b0, 4'h2, 1'b0};
    tbl[5]  = '{16'h2113, 2'b11, 1'b0, 1'b1, 16'h2010, 1'b1, 1'b0, 4'h2, 1'b0};
    tbl[6]  = '{16'h2214, 2'b11, 1'b0, 1'b1, 16'h2111, 1'b1, 1'b0, 4'h2, 1'b0};
    tbl[7]  = '{16'h2315, 2'b11, 1'b0, 1'b1, 16'h2212, 1'b1, 1'b0, 4'h2, 1'b0};
    tbl[8]  = '{16'h2416, 2'b01, 1'b0, 1'b1, 16'h2313, 1'b1, 1'b0, 4'h2, 1'b0};
    tbl[9]  = '{16'h2517, 2'b11, 1'b0, 1'b1, 16'h2414, 1'b1, 1'b1, 4'h2, 1'b1};
    tbl[10] = '{16'h2618, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'h2, 1'b0};

    reset = 1'b1; enable = 1'b1; packet_done = 1'b0; wait_for_sync = 1'b0;
    word_in = '0; valid_in = '0; ws4 = 1'b0; word4_in = '0; valid4_in = '0;
    tick(); tick();
    check("rst_word", 32'(word_out), 32'h0);
    check("rst_vout", 32'(valid_out), 32'h0);
    check("rst_pdo", 32'(packet_done_out), 32'h0);
    check("rst_taps", 32'(taps_out), 32'h0);
    check("rst_skew", 32'(skew_err), 32'h0);
    check("rst_drop", 32'(drop_err), 32'h0);
    check("rst_errc", 32'(err_count), 32'h0);
    check("rst_word4", word4_out, 32'h0);
    reset = 1'b0;

    // 4 lanes with offsets 0,3,1,2: sync bytes must meet in one word
    for (int r = 0; r < 6; r++) begin
      ws4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
        int n;
        n = r - off4[i];
        if (n >= 0) begin
          valid4_in[i] = 1'b1;
          word4_in[8*i +: 8] = (n == 0) ? 8'hB8 : {4'(i + 1), 4'(n)};
        end else begin
          valid4_in[i] = 1'b0;
          word4_in[8*i +: 8] = 8'h00;
        end
      end
      tick();
      check("l4_skew", 32'(skew4), 32'h0);
      if (r == 4) begin
        check("l4_sync_word", word4_out, 32'hB8B8B8B8);
        check("l4_sync_vout", 32'(valid4_out), 32'h0);
        check("l4_taps", 32'(taps4), 32'h63);
      end
      if (r == 5) begin
        check("l4_hdr_word", word4_out, 32'h41312111);
        check("l4_hdr_vout", 32'(valid4_out), 32'h1);
      end
    end
    valid4_in = '0; ws4 = 1'b0; word4_in = '0;

    // 2 lanes, lane0 two cycles early, then a one-cycle lane1 dropout
    for (int i = 0; i < 11; i++) begin
      word_in = tbl[i].w; valid_in = tbl[i].v; wait_for_sync = tbl[i].ws;
      tick();
      if (tbl[i].cw) check($sformatf("tbl%0d_word", i), 32'(word_out), 32'(tbl[i].ew));
      check($sformatf("tbl%0d_vout", i), 32'(valid_out), 32'(tbl[i].evo));
      check($sformatf("tbl%0d_pdo", i), 32'(packet_done_out), 32'(tbl[i].epdo));
      check($sformatf("tbl%0d_taps", i), 32'(taps_out), 32'(tbl[i].et));
      check($sformatf("tbl%0d_drop", i), 32'(drop_err), 32'(tbl[i].edrop));
      check($sformatf("tbl%0d_skew", i), 32'(skew_err), 32'h0);
    end

    // Over-range skew: lane0 valid 5 cycles, lane1 never valid
    do_reset();
    wait_for_sync = 1'b1;
    for (int j = 0; j < 10; j++) begin
      valid_in = (j < 5) ? 2'b01 : 2'b00;
      word_in  = 16'(16'h00A0 + j);
      tick();
      check($sformatf("skw%0d_err", j), 32'(skew_err), 32'(j == 4));
      check($sformatf("skw%0d_pdo", j), 32'(packet_done_out), 32'(j == 4));
      check($sformatf("skw%0d_vout", j), 32'(valid_out), 32'h0);
    end

    // packet_done and dropout in the same cycle
    do_reset();
    word_in = 16'h0101;
    valid_in = 2'b11; wait_for_sync = 1'b1; tick();
    tick();
    wait_for_sync = 1'b0; tick();
    check("pd_locked_vout", 32'(valid_out), 32'h1);
    valid_in = 2'b01; tick();
    check("pd_pre_drop", 32'(drop_err), 32'h0);
    valid_in = 2'b11; packet_done = 1'b1; tick();
    check("pd_same_drop", 32'(drop_err), 32'h0);
    check("pd_same_pdo", 32'(packet_done_out), 32'h1);
    check("pd_same_vout", 32'(valid_out), 32'h1);
    packet_done = 1'b0; tick();
    check("pd_after_drop", 32'(drop_err), 32'h0);
    check("pd_after_vout", 32'(valid_out), 32'h0);
    check("pd_after_pdo", 32'(packet_done_out), 32'h0);
    check("pd_errc", 32'(err_count), 32'h0);

    // Three skew errors in a row
    valid_in = 2'b00;
    for (int j = 0; j < 4; j++) tick();
    nskew = 0;
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int j = 0; j < 9; j++) begin
        valid_in = (j < 5) ? 2'b01 : 2'b00;
        tick();
        if (skew_err) nskew++;
      end
    end
    check("skw3_pulses", 32'(nskew), 32'd3);
`ifdef CSI_DESKEW_ERRCNT_EN
    check("skw3_errc", 32'(err_count), 32'd3);
`else
    check("skw3_errc", 32'(err_count), 32'd0);
`endif

    // enable low for 4 cycles mid-packet
    do_reset();
    n_acc = 0;
    for (int j = 0; j < 16; j++) begin
      enable = !(j >= 6 && j < 10);
      wait_for_sync = (j < 2);
      if (enable) begin
        word_in = item(n_acc); valid_in = 2'b11;
      end else begin
        word_in = 16'hDEAD; valid_in = 2'b00;
      end
      tick();
      if (enable) n_acc++;
      if (n_acc >= 3) begin
        check($sformatf("en%0d_word", j), 32'(word_out), 32'(item(n_acc - 2)));
        check($sformatf("en%0d_vout", j), 32'(valid_out), 32'h1);
      end
      check($sformatf("en%0d_drop", j), 32'(drop_err), 32'h0);
    end
    check("en_taps", 32'(taps_out), 32'h0);

    // Reset mid-packet while enable is low
    reset = 1'b1; enable = 1'b0; tick();
    check("mrst_word", 32'(word_out), 32'h0);
    check("mrst_vout", 32'(valid_out), 32'h0);
    check("mrst_taps", 32'(taps_out), 32'h0);
    check("mrst_pdo", 32'(packet_done_out), 32'h0);
    check("mrst_skew", 32'(skew_err), 32'h0);
    check("mrst_drop", 32'(drop_err), 32'h0);
    check("mrst_errc", 32'(err_count), 32'h0);
    reset = 1'b0; enable = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
